// File: rtl/shift_chain.sv
// shift_chain: DEPTH x WIDTH register line with per-stage valid, shift fwd/bwd, single-stage load and flush.
// Tracks occupancy and reports words that fall off either end.
module shift_chain #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int IDXW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable_i,
  input  logic [1:0]             mode_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   din_valid_i,
  input  logic [IDXW-1:0]        load_idx_i,
  input  logic [IDXW-1:0]        tap_sel_i,
  output logic [WIDTH*DEPTH-1:0] dout_all_o,
  output logic [DEPTH-1:0]       valid_all_o,
  output logic [WIDTH-1:0]       dout_tap_o,
  output logic                   tap_valid_o,
  output logic [IDXW:0]          count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   spill_o,
  output logic [WIDTH-1:0]       spill_data_o
);
  localparam logic [1:0] SHIFT_FWD = 2'b00;
  localparam logic [1:0] SHIFT_BWD = 2'b01;
  localparam logic [1:0] LOAD      = 2'b10;
  localparam logic [IDXW:0] DEPTH_W = (IDXW+1)'(DEPTH);
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [IDXW:0]               count_q, count_d;
  logic                        spill_q, spill_d;
  logic [WIDTH-1:0]            spill_data_q, spill_data_d;
  logic                        tap_ok;
  always_comb begin
    data_d       = data_q;
    valid_d      = valid_q;
    spill_d      = 1'b0;
    spill_data_d = spill_data_q;
    if (enable_i) begin
      if (mode_i == SHIFT_FWD) begin
        data_d       = {data_q[DEPTH-2:0], din_i};
        valid_d      = {valid_q[DEPTH-2:0], din_valid_i};
        spill_d      = valid_q[DEPTH-1];
        spill_data_d = valid_q[DEPTH-1] ? data_q[DEPTH-1] : spill_data_q;
      end else if (mode_i == SHIFT_BWD) begin
        data_d       = {din_i, data_q[DEPTH-1:1]};
        valid_d      = {din_valid_i, valid_q[DEPTH-1:1]};
        spill_d      = valid_q[0];
        spill_data_d = valid_q[0] ? data_q[0] : spill_data_q;
      end else if (mode_i == LOAD) begin
        if ({1'b0, load_idx_i} < DEPTH_W) begin
          data_d[load_idx_i]  = din_i;
          valid_d[load_idx_i] = din_valid_i;
        end
      end else begin
        data_d  = '0;
        valid_d = '0;
      end
    end
    count_d = '0;
    for (int i = 0; i < DEPTH; i++)
      count_d = count_d + (IDXW+1)'(valid_d[i]);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q       <= '0;
      valid_q      <= '0;
      count_q      <= '0;
      spill_q      <= 1'b0;
      spill_data_q <= '0;
    end else begin
      data_q       <= data_d;
      valid_q      <= valid_d;
      count_q      <= count_d;
      spill_q      <= spill_d;
      spill_data_q <= spill_data_d;
    end
  end
  assign tap_ok       = {1'b0, tap_sel_i} < DEPTH_W;
  assign dout_all_o   = data_q;
  assign valid_all_o  = valid_q;
  assign dout_tap_o   = tap_ok ? data_q[tap_sel_i] : '0;
  assign tap_valid_o  = tap_ok & valid_q[tap_sel_i];
  assign count_o      = count_q;
  assign full_o       = count_q == DEPTH_W;
  assign empty_o      = count_q == '0;
  assign spill_o      = spill_q;
  assign spill_data_o = spill_data_q;
endmodule

// File: tb/tb_shift_chain.sv
// tb_shift_chain: table-driven directed vectors for shift_chain (WIDTH=4, DEPTH=4)
// plus a hand-written asynchronous-reset sequence.
module tb_shift_chain;
  typedef struct {
    logic        en;
    logic [1:0]  mode;
    logic [3:0]  din;
    logic        dv;
    logic [1:0]  lidx;
    logic [1:0]  tsel;
    logic [15:0] dout;
    logic [3:0]  vld;
    logic [3:0]  tap;
    logic        tv;
    logic [2:0]  cnt;
    logic        sp;
    logic [3:0]  sd;
  } vec_t;
  logic        clk = 1'b0;
  logic        reset;
  logic        enable_i;
  logic [1:0]  mode_i;
  logic [3:0]  din_i;
  logic        din_valid_i;
  logic [1:0]  load_idx_i;
  logic [1:0]  tap_sel_i;
  logic [15:0] dout_all_o;
  logic [3:0]  valid_all_o;
  logic [3:0]  dout_tap_o;
  logic        tap_valid_o;
  logic [2:0]  count_o;
  logic        full_o;
  logic        empty_o;
  logic        spill_o;
  logic [3:0]  spill_data_o;
  int checks = 0;
  int failures = 0;
  vec_t vec[$];
  shift_chain #(.WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .enable_i(enable_i), .mode_i(mode_i), .din_i(din_i),
    .din_valid_i(din_valid_i), .load_idx_i(load_idx_i), .tap_sel_i(tap_sel_i),
    .dout_all_o(dout_all_o), .valid_all_o(valid_all_o), .dout_tap_o(dout_tap_o),
    .tap_valid_o(tap_valid_o), .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
    .spill_o(spill_o), .spill_data_o(spill_data_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [15:0] dout, input logic [3:0] vld,
                         input logic [3:0] tap, input logic tv, input logic [2:0] cnt,
                         input logic sp, input logic [3:0] sd);
    chk({tag, ".dout_all"}, dout_all_o, dout);
    chk({tag, ".valid_all"}, {12'd0, valid_all_o}, {12'd0, vld});
    chk({tag, ".dout_tap"}, {12'd0, dout_tap_o}, {12'd0, tap});
    chk({tag, ".tap_valid"}, {15'd0, tap_valid_o}, {15'd0, tv});
    chk({tag, ".count"}, {13'd0, count_o}, {13'd0, cnt});
    chk({tag, ".full"}, {15'd0, full_o}, {15'd0, cnt == 3'd4});
    chk({tag, ".empty"}, {15'd0, empty_o}, {15'd0, cnt == 3'd0});
    chk({tag, ".spill"}, {15'd0, spill_o}, {15'd0, sp});
    chk({tag, ".spill_data"}, {12'd0, spill_data_o}, {12'd0, sd});
  endtask
  task automatic add(input logic en, input logic [1:0] mode, input logic [3:0] din, input logic dv,
                     input logic [1:0] lidx, input logic [1:0] tsel, input logic [15:0] dout,
                     input logic [3:0] vld, input logic [3:0] tap, input logic tv,
                     input logic [2:0] cnt, input logic sp, input logic [3:0] sd);
    vec_t v;
    v.en = en; v.mode = mode; v.din = din; v.dv = dv; v.lidx = lidx; v.tsel = tsel;
    v.dout = dout; v.vld = vld; v.tap = tap; v.tv = tv; v.cnt = cnt; v.sp = sp; v.sd = sd;
    vec.push_back(v);
  endtask
  initial begin
    // fill to full, then one more word spills the oldest
    add(1'b1, 2'd0, 4'h1, 1'b1, 2'd0, 2'd0, 16'h0001, 4'b0001, 4'h1, 1'b1, 3'd1, 1'b0, 4'h0);
    add(1'b1, 2'd0, 4'h2, 1'b1, 2'd0, 2'd0, 16'h0012, 4'b0011, 4'h2, 1'b1, 3'd2, 1'b0, 4'h0);
    add(1'b1, 2'd0, 4'h3, 1'b1, 2'd0, 2'd0, 16'h0123, 4'b0111, 4'h3, 1'b1, 3'd3, 1'b0, 4'h0);
    add(1'b1, 2'd0, 4'h4, 1'b1, 2'd0, 2'd3, 16'h1234, 4'b1111, 4'h1, 1'b1, 3'd4, 1'b0, 4'h0);
    add(1'b1, 2'd0, 4'h5, 1'b1, 2'd0, 2'd3, 16'h2345, 4'b1111, 4'h2, 1'b1, 3'd4, 1'b1, 4'h1);
    add(1'b1, 2'd3, 4'h0, 1'b0, 2'd0, 2'd3, 16'h0000, 4'b0000, 4'h0, 1'b0, 3'd0, 1'b0, 4'h1);
    // load, then walk the word out backward
    add(1'b1, 2'd2, 4'hA, 1'b1, 2'd2, 2'd2, 16'h0A00, 4'b0100, 4'hA, 1'b1, 3'd1, 1'b0, 4'h1);
    add(1'b1, 2'd1, 4'h0, 1'b0, 2'd0, 2'd1, 16'h00A0, 4'b0010, 4'hA, 1'b1, 3'd1, 1'b0, 4'h1);
    add(1'b1, 2'd1, 4'h0, 1'b0, 2'd0, 2'd0, 16'h000A, 4'b0001, 4'hA, 1'b1, 3'd1, 1'b0, 4'h1);
    add(1'b1, 2'd1, 4'h7, 1'b1, 2'd0, 2'd0, 16'h7000, 4'b1000, 4'h0, 1'b0, 3'd1, 1'b1, 4'hA);
    // disabled cycles hold state and drop spill
    add(1'b0, 2'd0, 4'hF, 1'b1, 2'd0, 2'd3, 16'h7000, 4'b1000, 4'h7, 1'b1, 3'd1, 1'b0, 4'hA);
    add(1'b0, 2'd0, 4'hF, 1'b1, 2'd0, 2'd3, 16'h7000, 4'b1000, 4'h7, 1'b1, 3'd1, 1'b0, 4'hA);
    add(1'b0, 2'd0, 4'hF, 1'b1, 2'd0, 2'd3, 16'h7000, 4'b1000, 4'h7, 1'b1, 3'd1, 1'b0, 4'hA);
    add(1'b1, 2'd2, 4'hB, 1'b0, 2'd3, 2'd3, 16'hB000, 4'b0000, 4'hB, 1'b0, 3'd0, 1'b0, 4'hA);
    // invalid word leaving does not spill; then back-to-back spills
    add(1'b1, 2'd0, 4'hC, 1'b1, 2'd0, 2'd0, 16'h000C, 4'b0001, 4'hC, 1'b1, 3'd1, 1'b0, 4'hA);
    add(1'b1, 2'd0, 4'h1, 1'b1, 2'd0, 2'd1, 16'h00C1, 4'b0011, 4'hC, 1'b1, 3'd2, 1'b0, 4'hA);
    add(1'b1, 2'd0, 4'h2, 1'b1, 2'd0, 2'd1, 16'h0C12, 4'b0111, 4'h1, 1'b1, 3'd3, 1'b0, 4'hA);
    add(1'b1, 2'd0, 4'h3, 1'b1, 2'd0, 2'd3, 16'hC123, 4'b1111, 4'hC, 1'b1, 3'd4, 1'b0, 4'hA);
    add(1'b1, 2'd0, 4'h4, 1'b1, 2'd0, 2'd3, 16'h1234, 4'b1111, 4'h1, 1'b1, 3'd4, 1'b1, 4'hC);
    add(1'b1, 2'd0, 4'h5, 1'b1, 2'd0, 2'd3, 16'h2345, 4'b1111, 4'h2, 1'b1, 3'd4, 1'b1, 4'h1);
    add(1'b1, 2'd0, 4'h6, 1'b0, 2'd0, 2'd0, 16'h3456, 4'b1110, 4'h6, 1'b0, 3'd3, 1'b1, 4'h2);
    reset = 1'b1; enable_i = 1'b0; mode_i = 2'd0; din_i = 4'h0; din_valid_i = 1'b0;
    load_idx_i = 2'd0; tap_sel_i = 2'd0;
    repeat (2) @(negedge clk);
    chk_all("reset", 16'h0000, 4'b0000, 4'h0, 1'b0, 3'd0, 1'b0, 4'h0);
    reset = 1'b0;
    foreach (vec[k]) begin
      @(negedge clk);
      enable_i = vec[k].en; mode_i = vec[k].mode; din_i = vec[k].din;
      din_valid_i = vec[k].dv; load_idx_i = vec[k].lidx; tap_sel_i = vec[k].tsel;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", k), vec[k].dout, vec[k].vld, vec[k].tap, vec[k].tv,
              vec[k].cnt, vec[k].sp, vec[k].sd);
    end
    // count=3 and spill=1 now; reset between edges must clear at once
    #2 reset = 1'b1;
    #1 chk_all("async_reset", 16'h0000, 4'b0000, 4'h0, 1'b0, 3'd0, 1'b0, 4'h0);
    @(negedge clk);
    reset = 1'b0; enable_i = 1'b1; mode_i = 2'd0; din_i = 4'h9; din_valid_i = 1'b1; tap_sel_i = 2'd0;
    @(posedge clk);
    #1 chk_all("post_reset", 16'h0009, 4'b0001, 4'h9, 1'b1, 3'd1, 1'b0, 4'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
